// File: rtl/clock_cpu_debug_host_driver_if.sv
`default_nettype none
// ============================================================================
// Module   : clock_cpu_debug_host_driver_if
// Brief    : Command/response handshake bundle for the virtual-JTAG host driver.
// Revision : 1.0  initial release
// ============================================================================
interface clock_cpu_debug_host_driver_if #(
    parameter int DR_WIDTH = 38,
    parameter int IR_WIDTH = 2
) ();
    logic                cmd_valid;
    logic                cmd_ready;
    logic [IR_WIDTH-1:0] cmd_ir;
    logic [DR_WIDTH-1:0] cmd_dr;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [DR_WIDTH-1:0] rsp_dr;
    logic [IR_WIDTH-1:0] rsp_ir_out;

    modport master (
        output cmd_valid, cmd_ir, cmd_dr, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_dr, rsp_ir_out
    );

    modport slave (
        input  cmd_valid, cmd_ir, cmd_dr, rsp_ready,
        output cmd_ready, rsp_valid, rsp_dr, rsp_ir_out
    );
endinterface
`default_nettype wire

// File: rtl/clock_cpu_debug_host_driver.sv
`default_nettype none
// ============================================================================
// Module   : clock_cpu_debug_host_driver
// Brief    : Plays UIR/CDR/SDR/UDR virtual-JTAG sequences with a clk-derived tck.
// Revision : 1.0  initial release
// ============================================================================
module clock_cpu_debug_host_driver #(
    parameter int TCK_DIV  = 2,
    parameter int DR_WIDTH = 38,
    parameter int IR_WIDTH = 2
) (
    input  wire logic                clk,
    input  wire logic                reset_n,
    clock_cpu_debug_host_driver_if.slave host,
    output logic                     vji_tck,
    output logic                     vji_tdi,
    input  wire logic                vji_tdo,
    output logic [IR_WIDTH-1:0]      vji_ir_in,
    input  wire logic [IR_WIDTH-1:0] vji_ir_out,
    output logic                     vji_uir,
    output logic                     vji_cdr,
    output logic                     vji_sdr,
    output logic                     vji_udr,
    output logic                     vji_rti
);
    localparam int c_CNT_W = 8;
    localparam int c_BIT_W = $clog2(DR_WIDTH);
    localparam logic [c_CNT_W-1:0] c_DIV_LAST = c_CNT_W'(TCK_DIV - 1);
    localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(DR_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_UIR  = 3'd1,
        S_CDR  = 3'd2,
        S_SDR  = 3'd3,
        S_UDR  = 3'd4,
        S_RSP  = 3'd5
    } state_t;

    state_t              r_state;
    logic [c_CNT_W-1:0]  r_div_cnt;
    logic [c_BIT_W-1:0]  r_bit_cnt;
    logic                r_tck, r_tdi, r_uir, r_cdr, r_sdr, r_udr, r_rti;
    logic                r_cmd_ready, r_rsp_valid;
    logic [IR_WIDTH-1:0] r_ir_in, r_rsp_ir_out;
    logic [DR_WIDTH-1:0] r_sr, r_cap, r_rsp_dr;
    logic                w_half_end;

    assign w_half_end = (r_div_cnt == c_DIV_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_div_cnt    <= '0;
            r_bit_cnt    <= '0;
            r_tck        <= 1'b0;
            r_tdi        <= 1'b0;
            r_uir        <= 1'b0;
            r_cdr        <= 1'b0;
            r_sdr        <= 1'b0;
            r_udr        <= 1'b0;
            r_rti        <= 1'b1;
            r_cmd_ready  <= 1'b1;
            r_rsp_valid  <= 1'b0;
            r_ir_in      <= '0;
            r_rsp_ir_out <= '0;
            r_sr         <= '0;
            r_cap        <= '0;
            r_rsp_dr     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (host.cmd_valid) begin
                        r_sr        <= host.cmd_dr;
                        r_ir_in     <= host.cmd_ir;
                        r_state     <= S_UIR;
                        r_uir       <= 1'b1;
                        r_rti       <= 1'b0;
                        r_cmd_ready <= 1'b0;
                        r_div_cnt   <= '0;
                        r_tck       <= 1'b0;
                    end
                end
                S_RSP: begin
                    if (host.rsp_ready) begin
                        r_state     <= S_IDLE;
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                    end
                end
                S_UIR, S_CDR, S_SDR, S_UDR: begin
                    if (!w_half_end) begin
                        r_div_cnt <= r_div_cnt + 1'b1;
                    end else if (!r_tck) begin
                        // Rising tck: sample slave outputs before the slave reacts to this edge.
                        r_div_cnt <= '0;
                        r_tck     <= 1'b1;
                        if (r_state == S_UIR)
                            r_rsp_ir_out <= vji_ir_out;
                        if (r_state == S_SDR) begin
                            r_cap <= {vji_tdo, r_cap[DR_WIDTH-1:1]};
                            r_sr  <= {1'b0, r_sr[DR_WIDTH-1:1]};
                        end
                    end else begin
                        // Falling tck closes the period; strobes and tdi move only here.
                        r_div_cnt <= '0;
                        r_tck     <= 1'b0;
                        case (r_state)
                            S_UIR: begin
                                r_state <= S_CDR;
                                r_uir   <= 1'b0;
                                r_cdr   <= 1'b1;
                            end
                            S_CDR: begin
                                r_state   <= S_SDR;
                                r_cdr     <= 1'b0;
                                r_sdr     <= 1'b1;
                                r_tdi     <= r_sr[0];
                                r_bit_cnt <= '0;
                            end
                            S_SDR: begin
                                if (r_bit_cnt == c_BIT_LAST) begin
                                    r_state <= S_UDR;
                                    r_sdr   <= 1'b0;
                                    r_udr   <= 1'b1;
                                    r_tdi   <= 1'b0;
                                end else begin
                                    r_bit_cnt <= r_bit_cnt + 1'b1;
                                    r_tdi     <= r_sr[0];
                                end
                            end
                            default: begin
                                r_state     <= S_RSP;
                                r_udr       <= 1'b0;
                                r_rti       <= 1'b1;
                                r_rsp_valid <= 1'b1;
                                r_rsp_dr    <= r_cap;
                            end
                        endcase
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign host.cmd_ready  = r_cmd_ready;
    assign host.rsp_valid  = r_rsp_valid;
    assign host.rsp_dr     = r_rsp_dr;
    assign host.rsp_ir_out = r_rsp_ir_out;
    assign vji_tck         = r_tck;
    assign vji_tdi         = r_tdi;
    assign vji_ir_in       = r_ir_in;
    assign vji_uir         = r_uir;
    assign vji_cdr         = r_cdr;
    assign vji_sdr         = r_sdr;
    assign vji_udr         = r_udr;
    assign vji_rti         = r_rti;
endmodule
`default_nettype wire

// File: tb/tb_clock_cpu_debug_host_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_clock_cpu_debug_host_driver
// Brief    : Scoreboard bench with a behavioural virtual-JTAG slave model.
// Revision : 1.0  initial release
// ============================================================================
module tb_clock_cpu_debug_host_driver;
    localparam int DR   = 38;
    localparam int IR   = 2;
    localparam int LAT2 = (DR + 3) * 2 * 2;
    localparam int LAT1 = (DR + 3) * 2 * 1;
    localparam logic [50:0] c_RST = {6'b0, 1'b1, 2'b0, 38'b0, 2'b0, 1'b0, 1'b1};

    logic   clk = 1'b0;
    logic   reset_n;
    longint cyc = 0;
    int     n_tests = 0;
    int     n_fail  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    clock_cpu_debug_host_driver_if #(.DR_WIDTH(DR), .IR_WIDTH(IR)) h2 ();
    clock_cpu_debug_host_driver_if #(.DR_WIDTH(DR), .IR_WIDTH(IR)) h1 ();

    logic          tck2, tdi2, tdo2, uir2, cdr2, sdr2, udr2, rti2;
    logic [IR-1:0] ir_in2, irout2;
    logic          tck1, tdi1, tdo1, uir1, cdr1, sdr1, udr1, rti1;
    logic [IR-1:0] ir_in1, irout1;

    clock_cpu_debug_host_driver #(.TCK_DIV(2), .DR_WIDTH(DR), .IR_WIDTH(IR)) dut2 (
        .clk(clk), .reset_n(reset_n), .host(h2),
        .vji_tck(tck2), .vji_tdi(tdi2), .vji_tdo(tdo2), .vji_ir_in(ir_in2),
        .vji_ir_out(irout2), .vji_uir(uir2), .vji_cdr(cdr2), .vji_sdr(sdr2),
        .vji_udr(udr2), .vji_rti(rti2)
    );

    clock_cpu_debug_host_driver #(.TCK_DIV(1), .DR_WIDTH(DR), .IR_WIDTH(IR)) dut1 (
        .clk(clk), .reset_n(reset_n), .host(h1),
        .vji_tck(tck1), .vji_tdi(tdi1), .vji_tdo(tdo1), .vji_ir_in(ir_in1),
        .vji_ir_out(irout1), .vji_uir(uir1), .vji_cdr(cdr1), .vji_sdr(sdr1),
        .vji_udr(udr1), .vji_rti(rti1)
    );

    // Slave models: capture loads a preset word, shift-DR moves tdi in at the top.
    logic [DR-1:0] sr2 = '0, cap_val2 = '0, upd2 = '0;
    logic [IR-1:0] ir_seen2 = '0;
    int            rises2 = 0;
    always @(posedge tck2) begin
        rises2 <= rises2 + 1;
        if (uir2) ir_seen2 <= ir_in2;
        if (cdr2) sr2 <= cap_val2;
        else if (sdr2) sr2 <= {tdi2, sr2[DR-1:1]};
        if (udr2) upd2 <= sr2;
    end
    assign tdo2 = sr2[0];

    logic [DR-1:0] sr1 = '0, cap_val1 = '0, upd1 = '0;
    int            rises1 = 0;
    always @(posedge tck1) begin
        rises1 <= rises1 + 1;
        if (cdr1) sr1 <= cap_val1;
        else if (sdr1) sr1 <= {tdi1, sr1[DR-1:1]};
        if (udr1) upd1 <= sr1;
    end
    assign tdo1 = sr1[0];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [50:0] outs2();
        return {tck2, tdi2, uir2, cdr2, sdr2, udr2, rti2, ir_in2, h2.rsp_dr,
                h2.rsp_ir_out, h2.rsp_valid, h2.cmd_ready};
    endfunction

    function automatic logic [50:0] outs1();
        return {tck1, tdi1, uir1, cdr1, sdr1, udr1, rti1, ir_in1, h1.rsp_dr,
                h1.rsp_ir_out, h1.rsp_valid, h1.cmd_ready};
    endfunction

    typedef struct {
        logic [DR-1:0] dr;
        logic [DR-1:0] upd;
        logic [IR-1:0] ir;
        logic [IR-1:0] irout;
        longint        e0;
        int            rises;
    } exp_t;

    exp_t   sb[$];
    longint last_e0;
    logic   prev_rv = 1'b0;
    logic   prev_tdi = 1'b0;
    int     strobe_err = 0;
    int     tdi_err = 0;

    // Monitor: every new response on dut2 is matched against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        prev_rv  <= h2.rsp_valid;
        prev_tdi <= tdi2;
        if (reset_n && ($countones({uir2, cdr2, sdr2, udr2}) > 1)) strobe_err++;
        if (reset_n && (tdi2 !== prev_tdi) && tck2) tdi_err++;
        if (reset_n && h2.rsp_valid && !prev_rv) begin
            if (sb.size() == 0) begin
                check("unexpected_rsp", 64'(1), 64'(0));
            end else begin
                e = sb.pop_front();
                check("latency",    64'(cyc - e.e0),   64'(LAT2));
                check("rsp_dr",     64'(h2.rsp_dr),    64'(e.dr));
                check("rsp_ir_out", 64'(h2.rsp_ir_out), 64'(e.irout));
                check("slave_upd",  64'(upd2),         64'(e.upd));
                check("slave_ir",   64'(ir_seen2),     64'(e.ir));
                check("tck_rises",  64'(rises2),       64'(e.rises));
            end
        end
    end

    task automatic wait_ready2();
        for (int i = 0; i < 3000; i++) begin
            if (h2.cmd_ready) return;
            @(negedge clk);
        end
        check("cmd_ready_timeout", 64'(0), 64'(1));
    endtask

    task automatic wait_rsp2();
        for (int i = 0; i < 3000; i++) begin
            if (h2.rsp_valid) return;
            @(negedge clk);
        end
        check("rsp_valid_timeout", 64'(0), 64'(1));
    endtask

    task automatic send2(input logic [IR-1:0] ir, input logic [DR-1:0] dr,
                         input logic [DR-1:0] capv, input logic [IR-1:0] irout);
        exp_t e;
        wait_ready2();
        cap_val2     = capv;
        irout2       = irout;
        h2.cmd_ir    = ir;
        h2.cmd_dr    = dr;
        h2.cmd_valid = 1'b1;
        e.dr = capv; e.upd = dr; e.ir = ir; e.irout = irout;
        e.e0 = cyc + 1; e.rises = rises2 + DR + 3;
        last_e0 = e.e0;
        sb.push_back(e);
        @(negedge clk);
        h2.cmd_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        longint e0_1;
        int     r0_1, tck_bad, lat1;
        reset_n = 1'b0;
        h2.cmd_valid = 0; h2.cmd_ir = '0; h2.cmd_dr = '0; h2.rsp_ready = 1'b1;
        h1.cmd_valid = 0; h1.cmd_ir = '0; h1.cmd_dr = '0; h1.rsp_ready = 1'b1;
        irout2 = '0; irout1 = '0;

        // Reset held with random activity on every input.
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("reset_outs2", 64'(outs2()), 64'(c_RST));
            check("reset_outs1", 64'(outs1()), 64'(c_RST));
            h2.cmd_valid = 1'($urandom); h2.cmd_ir = IR'($urandom);
            h2.cmd_dr = {6'($urandom), 32'($urandom)}; h2.rsp_ready = 1'($urandom);
            h1.cmd_valid = 1'($urandom); h1.rsp_ready = 1'($urandom);
            irout2 = IR'($urandom); irout1 = IR'($urandom);
        end
        h2.cmd_valid = 0; h2.rsp_ready = 1'b1;
        h1.cmd_valid = 0; h1.rsp_ready = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Directed command with a busy-time cmd_valid pulse that must be dropped.
        send2(2'b01, 38'h2A_5555_AAAA, 38'h15_A5A5_5A5A, 2'b10);
        while (cyc < last_e0 + 49) @(negedge clk);
        h2.cmd_dr = 38'h3F_FFFF_FFFF; h2.cmd_valid = 1'b1;
        check("busy_cmd_ready", 64'(h2.cmd_ready), 64'(0));
        @(negedge clk);
        h2.cmd_valid = 1'b0;
        wait_rsp2();
        @(negedge clk);
        wait_ready2();

        // TCK_DIV=1 instance: latency, data and one-cycle tck halves.
        cap_val1 = 38'h15_A5A5_5A5A; irout1 = 2'b11;
        h1.cmd_ir = 2'b01; h1.cmd_dr = 38'h2A_5555_AAAA; h1.cmd_valid = 1'b1;
        e0_1 = cyc + 1; r0_1 = rises1; tck_bad = 0; lat1 = -1;
        @(negedge clk);
        h1.cmd_valid = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (tck1 !== 1'((cyc - e0_1) % 2)) tck_bad++;
            if (h1.rsp_valid) begin
                lat1 = int'(cyc - e0_1);
                break;
            end
            @(negedge clk);
        end
        check("div1_latency",   64'(lat1),       64'(LAT1));
        check("div1_rsp_dr",    64'(h1.rsp_dr),  64'(38'h15_A5A5_5A5A));
        check("div1_slave_upd", 64'(upd1),       64'(38'h2A_5555_AAAA));
        check("div1_ir_out",    64'(h1.rsp_ir_out), 64'(2'b11));
        check("div1_rises",     64'(rises1 - r0_1), 64'(DR + 3));
        check("div1_tck_shape", 64'(tck_bad),    64'(0));
        @(negedge clk);

        // Back-pressure: response held, second command ignored until handshake.
        h2.rsp_ready = 1'b0;
        send2(2'b10, 38'h0F_0F0F_F0F0, 38'h21_2345_6789, 2'b01);
        wait_rsp2();
        for (int i = 0; i < 10; i++) begin
            check("bp_rsp_valid",  64'(h2.rsp_valid), 64'(1));
            check("bp_rsp_dr",     64'(h2.rsp_dr),    64'(38'h21_2345_6789));
            check("bp_cmd_ready",  64'(h2.cmd_ready), 64'(0));
            h2.cmd_valid = (i >= 3 && i < 7);
            h2.cmd_dr    = 38'h3F_FFFF_FFFF;
            @(negedge clk);
        end
        h2.cmd_valid = 1'b0;
        h2.rsp_ready = 1'b1;
        @(negedge clk);
        check("post_hs_rsp_valid", 64'(h2.rsp_valid), 64'(0));
        check("post_hs_cmd_ready", 64'(h2.cmd_ready), 64'(1));
        check("post_hs_rsp_dr",    64'(h2.rsp_dr),    64'(38'h21_2345_6789));
        check("post_hs_ir_out",    64'(h2.rsp_ir_out), 64'(2'b01));

        // Reset in the middle of shift-DR, then a clean command.
        send2(2'b11, 38'h12_3456_789A, 38'h2B_CDEF_0123, 2'b10);
        while (cyc < last_e0 + 80) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midrst_outs2", 64'(outs2()), 64'(c_RST));
        sb.delete();
        repeat (3) @(negedge clk);
        check("midrst_tck_low", 64'(tck2), 64'(0));
        reset_n = 1'b1;
        @(negedge clk);
        send2(2'b01, 38'h2A_5555_AAAA, 38'h15_A5A5_5A5A, 2'b11);
        wait_rsp2();
        @(negedge clk);
        wait_ready2();

        // Random commands with random back-pressure and busy-time noise.
        for (int n = 0; n < 15; n++) begin
            send2(IR'($urandom), {6'($urandom), 32'($urandom)},
                  {6'($urandom), 32'($urandom)}, IR'($urandom));
            for (int i = 0; i < 3000; i++) begin
                if (h2.cmd_ready) break;
                h2.rsp_ready = 1'($urandom);
                h2.cmd_valid = !h2.rsp_valid && ($urandom_range(0, 7) == 0);
                h2.cmd_dr    = {6'($urandom), 32'($urandom)};
                @(negedge clk);
            end
            h2.cmd_valid = 1'b0;
            h2.rsp_ready = 1'b1;
        end
        repeat (200) @(negedge clk);
        check("sb_drained",  64'(sb.size()),  64'(0));
        check("strobe_excl", 64'(strobe_err), 64'(0));
        check("tdi_timing",  64'(tdi_err),    64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/clock_cpu_debug_host_driver.md
# clock_cpu_debug_host_driver

Host-side driver for the CPU debug slave's virtual-JTAG port. Accepts a command (2-bit IR plus 38-bit DR word) on a valid/ready interface. It plays the matching virtual-JTAG sequence: update-IR, capture-DR, 38-cycle shift-DR, update-DR, with `tck` generated from `clk`. It returns the 38-bit word shifted out of the slave's `tdo`. Used in simulation and self-test builds in place of the hard JTAG hub.

## Interface
- `TCK_DIV`, 2, `clk` cycles per `tck` half-period; legal range 1–255.
- `DR_WIDTH`, 38, shift-register length; fixed to match the slave's `sr`.
- `IR_WIDTH`, 2, instruction width.

- `clk`  in  1  system clock; all logic synchronous to its rising edge.
- `reset_n`  in  1  asynchronous active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  driver idle; a command is accepted when `cmd_valid & cmd_ready`.
- `cmd_ir`  in  IR_WIDTH  instruction for `ir_in`.
- `cmd_dr`  in  DR_WIDTH  data to shift in, LSB first.
- `rsp_valid`  out  1  response held until taken.
- `rsp_ready`  in  1  response consumed when `rsp_valid & rsp_ready`.
- `rsp_dr`  out  DR_WIDTH  word captured from `tdo`.
- `rsp_ir_out`  out  IR_WIDTH  `vji_ir_out`, sampled at the UIR rising `tck` edge.
- `vji_tck`  out  1  generated test clock.
- `vji_tdi`  out  1  serial data to the slave.
- `vji_tdo`  in  1  serial data from the slave.
- `vji_ir_in`  out  IR_WIDTH  instruction to the slave.
- `vji_ir_out`  in  IR_WIDTH  slave IR status.
- `vji_uir`  out  1  update-IR state.
- `vji_cdr`  out  1  capture-DR state.
- `vji_sdr`  out  1  shift-DR state.
- `vji_udr`  out  1  update-DR state.
- `vji_rti`  out  1  run-test-idle state.

## Operation
- States: IDLE → UIR → CDR → SDR → UDR → RSP → IDLE.
- Each of UIR, CDR and UDR lasts exactly one `tck` period. SDR lasts DR_WIDTH periods.
- IDLE:
  - `cmd_ready`=1, `vji_rti`=1, `tck`=0.
  - On accept: latch `cmd_ir` and `cmd_dr` into the shift register, drive `vji_ir_in`=`cmd_ir`, and enter UIR.
- `vji_ir_in` holds its value until the next accepted command.
- Strobes: exactly one of `uir`/`cdr`/`sdr`/`udr` is high in the matching state; all are low in IDLE and RSP.
- SDR:
  - `vji_tdi` = shift-register bit 0, updated only while `tck`=0.
  - On each rising `tck`, the driver samples `vji_tdo` into `cap` as `cap <= {tdo, cap[DR_WIDTH-1:1]}` and shifts the out-register right.
  - After DR_WIDTH rising edges, `cap` holds the slave's captured `sr`, with bit 0 shifted out first.
- RSP:
  - `rsp_valid`=1, `rsp_dr`=`cap`, `vji_rti`=1, `cmd_ready`=0.
  - On `rsp_ready`: return to IDLE. `cmd_ready` rises the next cycle.
- `cmd_valid` while busy is ignored and not queued.
- `rsp_dr` and `rsp_ir_out` keep their last values after the handshake.

## Timing
- Reset values:
  - `vji_tck`, `vji_tdi`, `vji_uir`, `vji_cdr`, `vji_sdr`, `vji_udr` = 0.
  - `vji_ir_in`, `rsp_dr`, `rsp_ir_out` = 0.
  - `rsp_valid` = 0; `cmd_ready` = 1; `vji_rti` = 1.
- Every `tck` period starts low:
  - `tck`=0 for TCK_DIV cycles, then `tck`=1 for TCK_DIV cycles.
  - State strobes and `tdi` change only on the `clk` edge that drives `tck` low.
  - This gives the slave TCK_DIV cycles of setup and hold around each rising edge.
- `tdo` is registered on the same `clk` edge that drives `tck` high.
- Latency: accept edge E0, UIR begins at E0. `rsp_valid` rises at E0 + (DR_WIDTH+3)·2·TCK_DIV, which is E0+164 for defaults.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Reset mid-operation:
  - Asynchronous return to reset values.
  - The in-flight command is dropped.
  - `tck` stops low, giving no partial rising edge.

## Test plan
- Reset: hold `reset_n`=0 with random inputs. All outputs equal the reset values; `cmd_ready`=1; `tck` stays 0 for 100 cycles.
- Single command, TCK_DIV=2, slave model `sr` preset 38'h15_A5A5_5A5A, `cmd_ir`=2'b01, `cmd_dr`=38'h2A_5555_AAAA:
  - `rsp_valid` rises at E0+164.
  - `rsp_dr`=38'h15_A5A5_5A5A.
  - Model `sr`=38'h2A_5555_AAAA at the `udr` rising edge.
  - Exactly 41 rising `tck` edges.
- TCK_DIV=1, same data: `rsp_valid` at E0+82; `tck` high and low 1 cycle each.
- Back-pressure: `rsp_ready`=0 for 10 cycles after `rsp_valid`. `rsp_valid` and `rsp_dr` are stable, `cmd_ready`=0, and a second `cmd_valid` is ignored until the handshake.
- Busy drop: pulse `cmd_valid` with `cmd_dr`=38'h3F_FFFF_FFFF at E0+50. It is not accepted, and the first command's response is unchanged.
- Reset mid-SDR: assert `reset_n`=0 at E0+80. Outputs reach reset values immediately. A new command after release completes normally with correct `rsp_dr`.
